// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory-wait timeout, illegal-opcode detection and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter bit          EN_IMM  = 1'b1,
  parameter bit          EN_JAL  = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       MemtoReg,
  output logic             IllegalOp,
  output logic             Fault,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int unsigned       WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              legal, timed_out, retire, waiting;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_LD, OP_ST, OP_BR: legal = 1'b1;
      OP_IMM:                    legal = EN_IMM;
      OP_JAL:                    legal = EN_JAL;
      default:                   legal = 1'b0;
    endcase
  end

  // MemReady is checked by the caller first, so a ready on the limit cycle wins.
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LIM) && !MemReady;

  always_comb begin
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    MemtoReg  = 2'b00;
    IllegalOp = 1'b0;
    Fault     = 1'b0;
    state_d   = state_q;
    op_d      = op_q;
    retire    = 1'b0;
    waiting   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        waiting = !MemReady;
        if (MemReady)       state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        op_d    = opcode;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          IllegalOp = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_WB;
          end
          OP_IMM: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 2'b11;
            state_d = S_WB;
          end
          OP_LD, OP_ST: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_MEM;
          end
          OP_BR: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 1'b1;
            PCWrite = Zero;
            retire  = 1'b1;
          end
          OP_JAL: begin
            PCSrc    = 1'b1;
            PCWrite  = 1'b1;
            RegWrite = 1'b1;
            MemtoReg = 2'b10;
            retire   = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        IorD    = 1'b1;
        waiting = !MemReady;
        if (op_q == OP_LD) MemRead  = 1'b1;
        else               MemWrite = 1'b1;
        if (MemReady) begin
          if (op_q == OP_LD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (op_q == OP_LD) ? 2'b01 : 2'b00;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_FAULT: Fault = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + 1'b1;
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_control;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] IM  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSrc,RegWrite,ALUSrcA,ALUSrcB,ALUOp,MemtoReg,IllegalOp,Fault}
  localparam logic [15:0] F1  = 16'b1001_1000_0100_0000;
  localparam logic [15:0] F0  = 16'b1000_0000_0100_0000;
  localparam logic [15:0] D   = 16'b0000_0000_1000_0000;
  localparam logic [15:0] DI  = 16'b0000_0000_1000_0010;
  localparam logic [15:0] ER  = 16'b0000_0001_0010_0000;
  localparam logic [15:0] EI  = 16'b0000_0001_1011_0000;
  localparam logic [15:0] EM  = 16'b0000_0001_1000_0000;
  localparam logic [15:0] EB0 = 16'b0000_0101_0001_0000;
  localparam logic [15:0] EB1 = 16'b0000_1101_0001_0000;
  localparam logic [15:0] EJ  = 16'b0000_1110_0000_1000;
  localparam logic [15:0] ML  = 16'b1010_0000_0000_0000;
  localparam logic [15:0] MS  = 16'b0110_0000_0000_0000;
  localparam logic [15:0] WL  = 16'b0000_0010_0000_0100;
  localparam logic [15:0] WR  = 16'b0000_0010_0000_0000;
  localparam logic [15:0] FT  = 16'b0000_0000_0000_0001;

  typedef struct {
    int unsigned idx;
    logic        sel;
    logic [2:0]  st;
    logic [15:0] ctl;
    int unsigned cnt;
  } exp_t;

  logic clk, rst_a, rst_b, zero, rdy;
  logic [6:0] op;

  logic mr_a, mw_a, iord_a, irw_a, pcw_a, pcs_a, rw_a, asa_a, ill_a, flt_a;
  logic [1:0] asb_a, aop_a, mtr_a;
  logic [2:0] st_a;
  logic [2:0] cnt_a;
  logic mr_b, mw_b, iord_b, irw_b, pcw_b, pcs_b, rw_b, asa_b, ill_b, flt_b;
  logic [1:0] asb_b, aop_b, mtr_b;
  logic [2:0] st_b;
  logic [31:0] cnt_b;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nstep  = 0;

  multicycle_control #(.TIMEOUT(4), .EN_IMM(1'b1), .EN_JAL(1'b1), .CNT_W(3)) u_a (
    .clk(clk), .rst_n(rst_a), .opcode(op), .Zero(zero), .MemReady(rdy),
    .MemRead(mr_a), .MemWrite(mw_a), .IorD(iord_a), .IRWrite(irw_a), .PCWrite(pcw_a),
    .PCSrc(pcs_a), .RegWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .ALUOp(aop_a),
    .MemtoReg(mtr_a), .IllegalOp(ill_a), .Fault(flt_a), .State(st_a), .InstrCount(cnt_a)
  );

  multicycle_control #(.TIMEOUT(0), .EN_IMM(1'b0), .EN_JAL(1'b0), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_b), .opcode(op), .Zero(zero), .MemReady(rdy),
    .MemRead(mr_b), .MemWrite(mw_b), .IorD(iord_b), .IRWrite(irw_b), .PCWrite(pcw_b),
    .PCSrc(pcs_b), .RegWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aop_b),
    .MemtoReg(mtr_b), .IllegalOp(ill_b), .Fault(flt_b), .State(st_b), .InstrCount(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0]  as;
      logic [15:0] ac;
      int unsigned an;
      e = q.pop_front();
      if (e.sel) begin
        as = st_b;
        ac = {mr_b, mw_b, iord_b, irw_b, pcw_b, pcs_b, rw_b, asa_b, asb_b, aop_b, mtr_b, ill_b, flt_b};
        an = cnt_b;
      end else begin
        as = st_a;
        ac = {mr_a, mw_a, iord_a, irw_a, pcw_a, pcs_a, rw_a, asa_a, asb_a, aop_a, mtr_a, ill_a, flt_a};
        an = 32'(cnt_a);
      end
      checks++;
      if (as !== e.st || ac !== e.ctl || an != e.cnt) begin
        errors++;
        $display("FAIL step%0d dut%0d: got state=%0d ctl=%b cnt=%0d, expected state=%0d ctl=%b cnt=%0d",
                 e.idx, e.sel, as, ac, an, e.st, e.ctl, e.cnt);
      end
    end
  end

  task automatic step(input logic sel, input logic rn, input logic [6:0] o, input logic z,
                      input logic r, input logic [2:0] es, input logic [15:0] ec,
                      input int unsigned en);
    exp_t e;
    e.idx = nstep; e.sel = sel; e.st = es; e.ctl = ec; e.cnt = en;
    nstep++;
    if (sel) rst_b = rn;
    else     rst_a = rn;
    op = o; zero = z; rdy = r;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; op = '0; zero = 1'b0; rdy = 1'b0;
    @(posedge clk);
    #1;

    // DUT A: TIMEOUT=4, CNT_W=3, all opcodes legal
    step(0, 0, R, 0, 0, 0, F0, 0);
    step(0, 1, R, 0, 1, 0, F1, 0);
    step(0, 1, R, 0, 1, 1, D, 0);
    step(0, 1, R, 0, 1, 2, ER, 0);
    step(0, 1, R, 0, 1, 4, WR, 0);
    step(0, 1, IM, 0, 1, 0, F1, 1);
    step(0, 1, IM, 0, 1, 1, D, 1);
    step(0, 1, IM, 0, 1, 2, EI, 1);
    step(0, 1, IM, 0, 1, 4, WR, 1);
    step(0, 1, LD, 0, 1, 0, F1, 2);
    step(0, 1, LD, 0, 1, 1, D, 2);
    step(0, 1, LD, 0, 1, 2, EM, 2);
    for (int i = 0; i < 3; i++) step(0, 1, LD, 0, 0, 3, ML, 2);
    step(0, 1, LD, 0, 1, 3, ML, 2);
    step(0, 1, LD, 0, 1, 4, WL, 2);
    step(0, 1, ST, 0, 1, 0, F1, 3);
    step(0, 1, ST, 0, 1, 1, D, 3);
    step(0, 1, ST, 0, 1, 2, EM, 3);
    step(0, 1, ST, 0, 0, 3, MS, 3);
    step(0, 1, ST, 0, 1, 3, MS, 3);
    step(0, 1, BR, 0, 1, 0, F1, 4);
    step(0, 1, BR, 0, 1, 1, D, 4);
    step(0, 1, BR, 0, 1, 2, EB0, 4);
    step(0, 1, BR, 1, 1, 0, F1, 5);
    step(0, 1, BR, 1, 1, 1, D, 5);
    step(0, 1, BR, 1, 1, 2, EB1, 5);
    step(0, 1, JL, 0, 1, 0, F1, 6);
    step(0, 1, JL, 0, 1, 1, D, 6);
    step(0, 1, JL, 0, 1, 2, EJ, 6);
    step(0, 1, BAD, 0, 1, 0, F1, 7);
    step(0, 1, BAD, 0, 1, 1, DI, 7);
    for (int i = 0; i < 3; i++) step(0, 1, R, 0, 0, 0, F0, 7);
    step(0, 1, R, 0, 1, 0, F1, 7);
    step(0, 1, R, 0, 1, 1, D, 7);
    step(0, 1, R, 0, 1, 2, ER, 7);
    step(0, 1, R, 0, 1, 4, WR, 7);
    step(0, 1, R, 0, 1, 0, F1, 0);
    step(0, 1, R, 0, 1, 1, D, 0);
    step(0, 1, R, 0, 1, 2, ER, 0);
    step(0, 1, R, 0, 1, 4, WR, 0);
    for (int i = 0; i < 4; i++) step(0, 1, R, 0, 0, 0, F0, 1);
    step(0, 1, R, 0, 0, 7, FT, 1);
    step(0, 1, R, 0, 1, 7, FT, 1);
    step(0, 0, R, 0, 0, 0, F0, 0);
    step(0, 1, LD, 0, 1, 0, F1, 0);
    step(0, 1, LD, 0, 1, 1, D, 0);
    step(0, 1, LD, 0, 1, 2, EM, 0);
    step(0, 1, LD, 0, 0, 3, ML, 0);
    step(0, 0, LD, 0, 0, 0, F0, 0);
    step(0, 1, R, 0, 1, 0, F1, 0);
    step(0, 1, R, 0, 1, 1, D, 0);
    step(0, 1, R, 0, 1, 2, ER, 0);
    step(0, 1, R, 0, 1, 4, WR, 0);
    step(0, 1, R, 0, 1, 0, F1, 1);
    rst_a = 1'b0;

    // DUT B: no timeout, I-type and JAL illegal
    step(1, 0, BAD, 0, 0, 0, F0, 0);
    step(1, 1, JL, 0, 1, 0, F1, 0);
    step(1, 1, JL, 0, 1, 1, DI, 0);
    step(1, 1, IM, 0, 1, 0, F1, 0);
    step(1, 1, IM, 0, 1, 1, DI, 0);
    step(1, 1, BAD, 0, 1, 0, F1, 0);
    step(1, 1, BAD, 0, 1, 1, DI, 0);
    for (int i = 0; i < 20; i++) step(1, 1, R, 0, 0, 0, F0, 0);
    step(1, 1, R, 0, 1, 0, F1, 0);
    step(1, 1, R, 0, 1, 1, D, 0);
    step(1, 1, R, 0, 1, 2, ER, 0);
    step(1, 1, R, 0, 1, 4, WR, 0);
    step(1, 1, R, 0, 1, 0, F1, 1);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
